// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver / register block and the receive FIFO.
// master: receiver + register interface side; slave: the FIFO itself.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    // Receiver side
    logic [7:0]  rsr;         // receiver shift register contents
    logic        valid_rx;    // receiver in STOP phase (level)
    logic [3:0]  data_len;    // character length, 5..8, others mean 8

    // Register interface controls
    logic        flush;       // synchronous FIFO clear
    logic        rd_en;       // pop request
    logic [AW:0] thresh;      // interrupt threshold, 0 disables
    logic        clr_ovr;     // clear sticky overrun

    // FIFO status / read port
    logic [7:0]  rd_data;     // head entry, 0 when empty
    logic        rd_valid;    // FIFO not empty
    logic        full;        // level == DEPTH
    logic [AW:0] level;       // stored entries, 0..DEPTH
    logic        overrun;     // sticky: a character was dropped
    logic        irq_thresh;  // thresh != 0 and level >= thresh

    modport master (
        output rsr, valid_rx, data_len, flush, rd_en, thresh, clr_ovr,
        input  rd_data, rd_valid, full, level, overrun, irq_thresh
    );

    modport slave (
        input  rsr, valid_rx, data_len, flush, rd_en, thresh, clr_ovr,
        output rd_data, rd_valid, full, level, overrun, irq_thresh
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO sitting behind the UART receiver. Each completed character
// (rising edge of valid_rx) is masked to the configured length and queued
// in a DEPTH-entry circular buffer with a show-ahead read port.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rstn,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          r_valid_d;           // previous valid_rx, for edge detect
    logic [AW:0]   r_wr_ptr;            // write pointer with wrap bit
    logic [AW:0]   r_rd_ptr;            // read pointer with wrap bit
    logic          r_overrun;           // sticky dropped-character flag
    logic [7:0]    r_mem [DEPTH];       // character storage

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          w_push;              // one-cycle pulse per character
    logic          w_empty;
    logic          w_full;
    logic          w_pop;               // accepted pop
    logic          w_wr_en;             // accepted push
    logic          w_drop;              // push lost because FIFO is full
    logic [AW:0]   w_level;
    logic [7:0]    w_mask;
    logic [7:0]    w_wr_data;

    // A new character is the rising edge of the STOP-phase level, so a
    // long STOP bit still yields exactly one push.
    assign w_push = bus.valid_rx & ~r_valid_d;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Pops on an empty FIFO are silently ignored; flush overrides both sides.
    assign w_pop   = bus.rd_en & ~w_empty & ~bus.flush;

    // When full, a same-cycle pop frees the head slot, which is exactly the
    // slot the write index points at, so the push can be accepted.
    assign w_wr_en = w_push & (~w_full | w_pop) & ~bus.flush;
    assign w_drop  = w_push & w_full & ~w_pop & ~bus.flush;

    // Decode the character length into a byte mask; unsupported lengths
    // fall back to a full 8-bit character.
    always_comb begin
        // NOTE: default assigned first so every path drives w_mask and no latch is inferred.
        w_mask = 8'hFF;
        unique case (bus.data_len)
            4'd5:    w_mask = 8'h1F;
            4'd6:    w_mask = 8'h3F;
            4'd7:    w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end

    assign w_wr_data = bus.rsr & w_mask;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Delay valid_rx by one cycle for rising-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (!rstn) begin
            r_valid_d <= 1'b0;
        end else begin
            r_valid_d <= bus.valid_rx;
        end
    end

    // Pointer management: flush clears both, otherwise advance on accepted
    // push and/or pop independently.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write; contents survive flush and reset.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; stale entries are unreachable because rd_data is gated by rd_valid.
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
        end
    end

    // Sticky overrun: a drop sets it and wins over a same-cycle clear;
    // flush leaves it alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all combinational from registered state
    // ------------------------------------------------------------------
    assign bus.rd_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign bus.rd_valid   = ~w_empty;
    assign bus.full       = w_full;
    assign bus.level      = w_level;
    assign bus.overrun    = r_overrun;
    assign bus.irq_thresh = (bus.thresh != '0) && (w_level >= bus.thresh);

endmodule
